gem_cluster_packer: RTL and testbench

- Upstream stage of the GEM trigger fiber transmitter.
- Collects GEM cluster candidates over one bunch crossing (two TRG_CLK80 cycles, 8 lanes per cycle) and compacts the first four valid clusters into a 56-bit word.
- Flags overflow when more than 8 clusters arrive in the bunch.
- GEM_DATA / GEM_OVERFLOW feed the fiber transmitter directly and are held stable for the full bunch, so both 80 MHz halves see the same word.

---
 rtl/gem_cluster_packer.sv | 196 +++++++++++++++++++
 tb/tb_gem_cluster_packer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/gem_cluster_packer.sv
// GEM cluster packer: gathers 16 candidates per bunch (2 x 8 lanes), keeps the first four valid.
// Optional drop/overflow statistics are built when GEM_PACKER_STATS_EN is defined.

module gem_cluster_lane #(
  parameter int CW = 14
) (
  input  logic          TRG_CLK80,
  input  logic          TRG_TXRESETDONE,
  input  logic          cap0_i,
  input  logic          cap1_i,
  input  logic          vld_i,
  input  logic [CW-1:0] clu_i,
  output logic          vld0_o,
  output logic [CW-1:0] clu0_o,
  output logic          vld1_o,
  output logic [CW-1:0] clu1_o
);
  always_ff @(posedge TRG_CLK80 or negedge TRG_TXRESETDONE) begin
    if (!TRG_TXRESETDONE) begin
      vld0_o <= 1'b0;
      clu0_o <= '0;
      vld1_o <= 1'b0;
      clu1_o <= '0;
    end else begin
      if (cap0_i) begin
        vld0_o <= vld_i;
        clu0_o <= clu_i;
      end
      if (cap1_i) begin
        vld1_o <= vld_i;
        clu1_o <= clu_i;
      end
    end
  end
endmodule

module gem_cluster_packer #(
  parameter int          NLANES     = 8,
  parameter int          OVF_THRESH = 8,
  parameter logic [13:0] EMPTY_CLU  = 14'h3FFF
) (
  input  logic                 TRG_CLK80,
  input  logic                 TRG_TXRESETDONE,
  input  logic                 BX_SYNC,
  input  logic [NLANES-1:0]    CLU_VALID,
  input  logic [NLANES*14-1:0] CLU_DATA,
  output logic [55:0]          GEM_DATA,
  output logic                 GEM_OVERFLOW,
  output logic [4:0]           GEM_COUNT,
  output logic                 LOCKED,
  output logic                 RESYNC,
  output logic [15:0]          DROP_CNT,
  output logic [15:0]          OVF_CNT
);
  localparam int CW    = 14;
  localparam int NSLOT = 4;
  localparam int NCAND = 2 * NLANES;

  typedef enum logic [1:0] {IDLE, PH0, PH1} state_t;

  state_t state_q, state_d;
  logic   cap0, cap1, ld_bunch, ld_empty;

  logic [NLANES-1:0]         vld0, vld1;
  logic [NLANES-1:0][CW-1:0] clu0, clu1;

  for (genvar g = 0; g < NLANES; g++) begin : g_lane
    gem_cluster_lane #(.CW(CW)) u_lane (
      .TRG_CLK80      (TRG_CLK80),
      .TRG_TXRESETDONE(TRG_TXRESETDONE),
      .cap0_i         (cap0),
      .cap1_i         (cap1),
      .vld_i          (CLU_VALID[g]),
      .clu_i          (CLU_DATA[CW*g +: CW]),
      .vld0_o         (vld0[g]),
      .clu0_o         (clu0[g]),
      .vld1_o         (vld1[g]),
      .clu1_o         (clu1[g])
    );
  end

  always_ff @(posedge TRG_CLK80 or negedge TRG_TXRESETDONE) begin
    if (!TRG_TXRESETDONE) state_q <= IDLE;
    else                  state_q <= state_d;
  end

  // A BX_SYNC landing on a phase-1 edge restarts the bunch on this edge.
  always_comb begin
    state_d  = state_q;
    cap0     = 1'b0;
    cap1     = 1'b0;
    ld_bunch = 1'b0;
    ld_empty = 1'b0;
    case (state_q)
      IDLE: if (BX_SYNC) begin
        cap0    = 1'b1;
        state_d = PH1;
      end
      PH1: begin
        if (BX_SYNC) begin
          cap0     = 1'b1;
          ld_empty = 1'b1;
        end else begin
          cap1    = 1'b1;
          state_d = PH0;
        end
      end
      PH0: begin
        cap0     = 1'b1;
        ld_bunch = 1'b1;
        state_d  = PH1;
      end
      default: state_d = IDLE;
    endcase
  end

  logic [NCAND-1:0]         cand_vld;
  logic [NCAND-1:0][CW-1:0] cand_clu;
  logic [NSLOT-1:0][CW-1:0] slot_d;
  logic [4:0]               cnt_d;
  logic                     ovf_d;

  assign cand_vld = {vld1, vld0};
  assign cand_clu = {clu1, clu0};

  always_comb begin
    slot_d = {NSLOT{EMPTY_CLU}};
    cnt_d  = '0;
    for (int i = 0; i < NCAND; i++) begin
      if (cand_vld[i]) begin
        if (cnt_d < 5'(NSLOT)) slot_d[cnt_d[1:0]] = cand_clu[i];
        cnt_d = cnt_d + 5'd1;
      end
    end
  end

  assign ovf_d = (cnt_d > 5'(OVF_THRESH));

  logic [NSLOT-1:0][CW-1:0] data_q;
  logic [4:0]               cnt_q;
  logic                     ovf_q, resync_q;

  always_ff @(posedge TRG_CLK80 or negedge TRG_TXRESETDONE) begin
    if (!TRG_TXRESETDONE) begin
      data_q   <= {NSLOT{EMPTY_CLU}};
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      resync_q <= 1'b0;
    end else begin
      resync_q <= ld_empty;
      if (ld_bunch) begin
        data_q <= slot_d;
        cnt_q  <= cnt_d;
        ovf_q  <= ovf_d;
      end else if (ld_empty) begin
        data_q <= {NSLOT{EMPTY_CLU}};
        cnt_q  <= '0;
        ovf_q  <= 1'b0;
      end
    end
  end

  assign GEM_DATA     = data_q;
  assign GEM_COUNT    = cnt_q;
  assign GEM_OVERFLOW = ovf_q;
  assign RESYNC       = resync_q;
  assign LOCKED       = (state_q != IDLE);

`ifdef GEM_PACKER_STATS_EN
  logic [15:0] drop_q, ovfc_q;
  logic [4:0]  drop_inc;
  logic [16:0] drop_sum, ovfc_sum;

  assign drop_inc = (cnt_d > 5'(NSLOT)) ? cnt_d - 5'(NSLOT) : 5'd0;
  assign drop_sum = {1'b0, drop_q} + 17'(drop_inc);
  assign ovfc_sum = {1'b0, ovfc_q} + 17'(ovf_d);

  // Saturate instead of wrapping; resync loads leave the counters alone.
  always_ff @(posedge TRG_CLK80 or negedge TRG_TXRESETDONE) begin
    if (!TRG_TXRESETDONE) begin
      drop_q <= '0;
      ovfc_q <= '0;
    end else if (ld_bunch) begin
      drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      ovfc_q <= ovfc_sum[16] ? 16'hFFFF : ovfc_sum[15:0];
    end
  end

  assign DROP_CNT = drop_q;
  assign OVF_CNT  = ovfc_q;
`else
  assign DROP_CNT = '0;
  assign OVF_CNT  = '0;
`endif

endmodule

// File: tb/tb_gem_cluster_packer.sv
// Randomized bench for gem_cluster_packer: a per-edge bunch model feeds a scoreboard queue
// that a negedge monitor drains against the DUT outputs.
module tb_gem_cluster_packer;
  localparam logic [13:0] EMPTY = 14'h3FFF;

  logic         TRG_CLK80 = 1'b0;
  logic         TRG_TXRESETDONE = 1'b0;
  logic         BX_SYNC = 1'b0;
  logic [7:0]   CLU_VALID = '0;
  logic [111:0] CLU_DATA = '0;
  logic [55:0]  GEM_DATA;
  logic         GEM_OVERFLOW;
  logic [4:0]   GEM_COUNT;
  logic         LOCKED, RESYNC;
  logic [15:0]  DROP_CNT, OVF_CNT;

  gem_cluster_packer dut (
    .TRG_CLK80      (TRG_CLK80),
    .TRG_TXRESETDONE(TRG_TXRESETDONE),
    .BX_SYNC        (BX_SYNC),
    .CLU_VALID      (CLU_VALID),
    .CLU_DATA       (CLU_DATA),
    .GEM_DATA       (GEM_DATA),
    .GEM_OVERFLOW   (GEM_OVERFLOW),
    .GEM_COUNT      (GEM_COUNT),
    .LOCKED         (LOCKED),
    .RESYNC         (RESYNC),
    .DROP_CNT       (DROP_CNT),
    .OVF_CNT        (OVF_CNT)
  );

  always #5 TRG_CLK80 = ~TRG_CLK80;

  typedef struct packed {
    logic [55:0] data;
    logic [4:0]  cnt;
    logic        ovf;
    logic        locked;
    logic        resync;
    logic [15:0] drop;
    logic [15:0] ovfc;
  } obs_t;

  obs_t sb[$];
  int   n_pass = 0, n_total = 0, cyc = 0;

  // Reference model: a bunch is just the ordered list of valid clusters seen so far.
  obs_t        cur;
  bit          m_locked, m_e1;
  logic [13:0] m_bunch[$];
  int          m_drop, m_ovfc;

  function automatic void add_lanes(logic [7:0] v, logic [111:0] d);
    for (int k = 0; k < 8; k++) if (v[k]) m_bunch.push_back(d[14*k +: 14]);
  endfunction

  function automatic void model_reset();
    m_locked = 0; m_e1 = 0; m_bunch.delete(); m_drop = 0; m_ovfc = 0;
    cur.data = {4{EMPTY}}; cur.cnt = 0; cur.ovf = 0;
    cur.locked = 0; cur.resync = 0; cur.drop = 0; cur.ovfc = 0;
  endfunction

  function automatic void model_edge(bit bx, logic [7:0] v, logic [111:0] d);
    int n;
    cur.resync = 0;
    if (!m_locked) begin
      if (bx) begin
        m_locked = 1; m_bunch.delete(); add_lanes(v, d); m_e1 = 1;
      end
    end else if (m_e1) begin
      if (bx) begin
        m_bunch.delete(); add_lanes(v, d);
        cur.data = {4{EMPTY}}; cur.cnt = 0; cur.ovf = 0; cur.resync = 1;
      end else begin
        add_lanes(v, d); m_e1 = 0;
      end
    end else begin
      n = m_bunch.size();
      cur.data = {4{EMPTY}};
      for (int i = 0; i < 4 && i < n; i++) cur.data[14*i +: 14] = m_bunch[i];
      cur.cnt = 5'(n);
      cur.ovf = (n > 8);
`ifdef GEM_PACKER_STATS_EN
      m_drop = (n > 4) ? m_drop + n - 4 : m_drop;
      if (m_drop > 65535) m_drop = 65535;
      if (n > 8 && m_ovfc < 65535) m_ovfc++;
`endif
      m_bunch.delete(); add_lanes(v, d); m_e1 = 1;
    end
    cur.locked = m_locked;
    cur.drop = 16'(m_drop);
    cur.ovfc = 16'(m_ovfc);
  endfunction

  function automatic logic [111:0] rand_data();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[111:0];
  endfunction

  task automatic cycle(input bit bx, input logic [7:0] v, input logic [111:0] d);
    BX_SYNC = bx; CLU_VALID = v; CLU_DATA = d;
    @(posedge TRG_CLK80);
    model_edge(bx, v, d);
    sb.push_back(cur);
    #1;
  endtask

  task automatic do_reset();
    @(negedge TRG_CLK80); #2;
    TRG_TXRESETDONE = 1'b0;
    model_reset();
    sb.push_back(cur);
    @(negedge TRG_CLK80); @(negedge TRG_CLK80); #2;
    TRG_TXRESETDONE = 1'b1;
  endtask

  always @(negedge TRG_CLK80) begin
    obs_t a, e;
    cyc++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = '{GEM_DATA, GEM_COUNT, GEM_OVERFLOW, LOCKED, RESYNC, DROP_CNT, OVF_CNT};
      n_total++;
      if (a === e) n_pass++;
      else $display("FAIL outputs cyc%0d: got data=%h cnt=%0d ovf=%b lock=%b rsy=%b drop=%h ovfc=%h, want data=%h cnt=%0d ovf=%b lock=%b rsy=%b drop=%h ovfc=%h",
        cyc, a.data, a.cnt, a.ovf, a.locked, a.resync, a.drop, a.ovfc,
        e.data, e.cnt, e.ovf, e.locked, e.resync, e.drop, e.ovfc);
    end
  end

  initial begin
    logic [111:0] d;
    model_reset();
    do_reset();
    // Unlocked: random traffic without BX_SYNC must not disturb outputs.
    for (int i = 0; i < 20; i++) cycle(0, 8'($urandom), rand_data());
    // Single cluster on phase-0 lane 5.
    d = rand_data(); d[70 +: 14] = 14'h0123;
    cycle(1, 8'b0010_0000, d);
    cycle(0, 8'h00, rand_data());
    // Lane-index data: phase-0 lanes 1,6 then phase-1 lanes 0,7.
    for (int k = 0; k < 8; k++) d[14*k +: 14] = 14'(k);
    cycle(0, 8'b0100_0010, d);
    cycle(0, 8'b1000_0001, d);
    // Nine valid: overflow.
    cycle(0, 8'hFF, rand_data());
    cycle(0, 8'b0000_1000, rand_data());
    // Saturation run: every lane valid.
    for (int b = 0; b < 5600; b++) begin
      cycle(0, 8'hFF, rand_data());
      cycle(0, 8'hFF, rand_data());
    end
    // Misaligned BX_SYNC on an E1 edge, then realigned bunches.
    cycle(0, 8'($urandom), rand_data());
    cycle(1, 8'($urandom), rand_data());
    for (int i = 0; i < 8; i++) cycle(0, 8'($urandom), rand_data());
    // Random traffic with occasional BX_SYNC at either phase.
    for (int i = 0; i < 800; i++)
      cycle(($urandom_range(0, 19) == 0), 8'($urandom), rand_data());
    // Reset mid-bunch, relock, more random traffic.
    cycle(0, 8'($urandom), rand_data());
    do_reset();
    for (int i = 0; i < 5; i++) cycle(0, 8'($urandom), rand_data());
    cycle(1, 8'($urandom), rand_data());
    for (int i = 0; i < 200; i++)
      cycle(($urandom_range(0, 29) == 0), 8'($urandom), rand_data());
    BX_SYNC = 0;
    @(negedge TRG_CLK80); @(negedge TRG_CLK80); #1;
    n_total++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending, want 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
